pwm_multi: RTL

- Multi-channel, parametrised successor to the single-channel 8-bit PWM generator.
- CHANNELS independent duty-cycle outputs share one programmable-period counter.
- Adds a selectable edge-aligned or center-aligned mode, double-buffered (shadow) duty/period/mode registers applied only at period boundaries, an enable, and a period-end strobe.
- Sits between control logic (e.g. sine-table sequencer) and output pins/filters.

---
 rtl/pwm_multi_if.sv | 34 +++
 rtl/pwm_multi.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pwm_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_if
//  Description : Control/status bundle for the multi-channel PWM generator.
//                The controller drives the requested settings and the update
//                strobe; the generator returns the PWM outputs and the
//                period-end strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                         en;
  logic [WIDTH-1:0]             period;
  logic [CHANNELS*WIDTH-1:0]    width;
  logic                         center;
  logic                         upd;
  logic [CHANNELS-1:0]          pwm;
  logic                         period_end;

  // Controller side: owns the requested settings, observes the outputs.
  modport master (
    output en, period, width, center, upd,
    input  pwm, period_end
  );

  // Generator side.
  modport slave (
    input  en, period, width, center, upd,
    output pwm, period_end
  );
endinterface
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi
//  Description : CHANNELS-output PWM generator sharing one programmable
//                counter. Edge- or center-aligned counting, shadowed
//                period/duty/mode registers applied at period boundaries,
//                enable and a registered period-end strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  pwm_multi_if.slave  bus
);

  localparam logic [0:0]       c_DIR_UP    = 1'b0;
  localparam logic [0:0]       c_DIR_DOWN  = 1'b1;
  localparam logic [0:0]       c_MODE_EDGE = 1'b0;
  localparam logic [WIDTH-1:0] c_ZERO      = '0;
  localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_ALL_ONES  = '1;

  // Counter state
  logic [WIDTH-1:0]          r_cnt;
  logic [0:0]                r_dir;
  logic                      r_pend;

  // Active (working) copies of the shadowed settings
  logic [WIDTH-1:0]          r_per_a;
  logic [CHANNELS*WIDTH-1:0] r_duty_a;
  logic [0:0]                r_mode_a;

  // Registered outputs
  logic [CHANNELS-1:0]       r_pwm;
  logic                      r_pe;

  logic                      w_boundary;
  logic                      w_load;
  logic [WIDTH-1:0]          w_cnt_nxt;
  logic [0:0]                w_dir_nxt;
  logic [CHANNELS-1:0]       w_cmp;

  // Last cycle of the current period: the counter returns to 0 next.
  // In center mode with a top count of 1 there is no down-count phase, so
  // the top itself is the last cycle.
  always_comb begin
    w_boundary = 1'b0;
    if (r_per_a == c_ZERO) begin
      w_boundary = 1'b1;
    end else if (r_mode_a == c_MODE_EDGE) begin
      w_boundary = (r_cnt == r_per_a);
    end else begin
      w_boundary = (r_cnt == c_ONE) &&
                   ((r_dir == c_DIR_DOWN) || (r_per_a == c_ONE));
    end
  end

  // While disabled an update lands at once; while running it waits for
  // the boundary, using whatever inputs are present on that cycle.
  assign w_load = bus.en ? (w_boundary & (r_pend | bus.upd)) : bus.upd;

  // Next counter value and direction.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (!bus.en || w_boundary) begin
      w_cnt_nxt = c_ZERO;
      w_dir_nxt = c_DIR_UP;
    end else if (r_mode_a == c_MODE_EDGE) begin
      w_cnt_nxt = r_cnt + c_ONE;
      w_dir_nxt = c_DIR_UP;
    end else if (r_dir == c_DIR_UP) begin
      if (r_cnt == r_per_a) begin
        w_cnt_nxt = r_cnt - c_ONE;
        w_dir_nxt = c_DIR_DOWN;
      end else begin
        w_cnt_nxt = r_cnt + c_ONE;
      end
    end else begin
      w_cnt_nxt = r_cnt - c_ONE;
    end
  end

  // One comparator per channel against the shared counter.
  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign w_cmp[k] = (r_cnt < r_duty_a[k*WIDTH +: WIDTH]);
    end
  endgenerate

  // Counter, pending flag and active-register update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= c_ZERO;
      r_dir    <= c_DIR_UP;
      r_pend   <= 1'b0;
      r_per_a  <= c_ALL_ONES;
      r_duty_a <= '0;
      r_mode_a <= c_MODE_EDGE;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
      if (w_load) begin
        r_pend   <= 1'b0;
        r_per_a  <= bus.period;
        r_duty_a <= bus.width;
        r_mode_a <= bus.center;
      end else begin
        r_pend   <= r_pend | bus.upd;
      end
    end
  end

  // Output registers: compare result and boundary strobe, gated by enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm <= '0;
      r_pe  <= 1'b0;
    end else begin
      r_pwm <= bus.en ? w_cmp : '0;
      r_pe  <= bus.en & w_boundary;
    end
  end

  assign bus.pwm        = r_pwm;
  assign bus.period_end = r_pe;

endmodule
`default_nettype wire
